// File: rtl/dbus_pkg.sv
// Shared types and defaults for the two-master data RAM arbiter.
package dbus_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic mst_idx_t;

    localparam logic [DATA_W_DEF/8-1:0] WSTRB_READ = '0;

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of both master request ports and the shared RAM port.
interface dbus_arbiter_if
    import dbus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int STRB_W = DATA_W / 8;

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view: serves the masters, drives the RAM.
    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wstrb,
        output m0_done, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_wdata, m1_wstrb,
        output m1_done, m1_rdata, m1_err,
        output mem_req, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    // Environment view: requesting masters plus the RAM.
    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wstrb,
        input  m0_done, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_wdata, m1_wstrb,
        input  m1_done, m1_rdata, m1_err,
        input  mem_req, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on a strobed grant.
module rr_arbiter2
    import dbus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic [1:0] gnt_o
);

    mst_idx_t last_q;

    // Reset value 1 means master 0 wins the first tie.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (grant_en_i && (|req_i)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master, one-slave data RAM arbiter with round-robin grant and done pulses.
// Optional BUSY watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    dbus_arbiter_if.slave bus,
    output logic         busy
);

    localparam int STRB_W = DATA_W / 8;

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("dbus_arbiter: TIMEOUT must be at least 2");
    end

    state_t            state_q;
    mst_idx_t          gnt_idx_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [1:0]        done_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              busy_q;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              grant_en;
    logic              expire;
    logic [DATA_W-1:0] rdata_d;

    assign req      = {bus.m1_req, bus.m0_req};
    assign grant_en = (state_q == IDLE);

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .grant_en_i (grant_en),
        .gnt_o      (gnt)
    );

`ifdef DBUS_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       err_q;
    logic             err_d;

    assign expire = (cnt_q == CNT_LAST);
    assign err_d  = ~bus.mem_ack;
`else
    assign expire = 1'b0;
`endif

    // Writes and timeouts return zero data.
    assign rdata_d = (bus.mem_ack && (mem_wstrb_q == STRB_W'(WSTRB_READ))) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_idx_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            done_q      <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 2'b00;
`endif
        end else begin
            done_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        mem_addr_q  <= gnt[0] ? bus.m0_addr  : bus.m1_addr;
                        mem_wdata_q <= gnt[0] ? bus.m0_wdata : bus.m1_wdata;
                        mem_wstrb_q <= gnt[0] ? bus.m0_wstrb : bus.m1_wstrb;
                        gnt_idx_q   <= gnt[1];
                        mem_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= BUSY;
`ifdef DBUS_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                BUSY: begin
                    // An ack coinciding with expiry completes normally.
                    if (bus.mem_ack || expire) begin
                        mem_req_q         <= 1'b0;
                        done_q[gnt_idx_q] <= 1'b1;
                        state_q           <= RESP;
                        if (gnt_idx_q) begin
                            rdata1_q <= rdata_d;
                        end else begin
                            rdata0_q <= rdata_d;
                        end
`ifdef DBUS_TIMEOUT_EN
                        err_q[gnt_idx_q] <= err_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.m0_done   = done_q[0];
    assign bus.m1_done   = done_q[1];
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
`ifdef DBUS_TIMEOUT_EN
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
`else
    assign bus.m0_err    = 1'b0;
    assign bus.m1_err    = 1'b0;
`endif
    assign busy          = busy_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: expected completions queued at request time, checked on done.
module tb_dbus_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct packed {
        logic        mst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   ack_wait  = 0;
    int   wcnt      = 0;
    bit   mem_en    = 1'b1;
    bit   force_ack = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // RAM model: ack after ack_wait extra BUSY cycles, data derived from the address.
    always @(posedge clk) begin
        #2;
        bus.mem_ack = 1'b0;
        if (force_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hBAD0BAD0;
        end else if (mem_en && bus.mem_req) begin
            if (wcnt == ack_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd_fn(bus.mem_addr);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Completion monitor.
    always @(posedge clk) begin
        #1;
        if (!reset && (bus.m0_done || bus.m1_done)) begin
            check_val("done_onehot", 32'(bus.m0_done) + 32'(bus.m1_done), 32'd1);
            if (exp_q.size() == 0) begin
                check_val("done_unexpected", {30'b0, bus.m1_done, bus.m0_done}, 32'd0);
            end else begin
                exp_cur = exp_q.pop_front();
                check_val("done_mst", {31'b0, bus.m1_done}, {31'b0, exp_cur.mst});
                check_val("done_rdata", bus.m1_done ? bus.m1_rdata : bus.m0_rdata, exp_cur.rdata);
                check_val("done_err", {31'b0, bus.m1_done ? bus.m1_err : bus.m0_err}, {31'b0, exp_cur.err});
            end
        end
    end

    task automatic expect_done(input logic m, input logic [31:0] r, input logic e);
        exp_t x;
        x.mst   = m;
        x.rdata = r;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    task automatic drive_req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s; bus.m0_req = 1'b1;
        end else begin
            bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s; bus.m1_req = 1'b1;
        end
    endtask

    // Drop each request in its done cycle and wait for the arbiter to settle.
    task automatic run_idle(input int bound);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            if (bus.m0_done) bus.m0_req = 1'b0;
            if (bus.m1_done) bus.m1_req = 1'b0;
            cyc++;
        end while ((bus.m0_req || bus.m1_req || busy) && cyc < bound);
        check_val("drain_busy", {31'b0, busy}, 32'd0);
        check_val("drain_sb", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
        bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check_val("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check_val("rst_mem_addr", bus.mem_addr, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {30'b0, bus.m1_done, bus.m0_done}, 32'd0);
        check_val("rst_rdata0", bus.m0_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Tie after reset: m0 first, then m1.
        ack_wait = 0;
        expect_done(1'b0, rd_fn(32'h100), 1'b0);
        expect_done(1'b1, rd_fn(32'h200), 1'b0);
        drive_req(0, 32'h100, 32'h0, 4'b0000);
        drive_req(1, 32'h200, 32'h0, 4'b0000);
        run_idle(40);

        // Single read with two wait cycles.
        ack_wait = 2;
        expect_done(1'b0, 32'hDEADBEEF, 1'b0);
        drive_req(0, 32'h10, 32'h0, 4'b0000);
        @(negedge clk);
        check_val("rd_mem_req", {31'b0, bus.mem_req}, 32'd1);
        check_val("rd_mem_addr", bus.mem_addr, 32'h10);
        check_val("rd_busy", {31'b0, busy}, 32'd1);
        run_idle(20);

        // Tie again with m0 granted last: m1 first.
        ack_wait = 1;
        expect_done(1'b1, rd_fn(32'h204), 1'b0);
        expect_done(1'b0, rd_fn(32'h104), 1'b0);
        drive_req(0, 32'h104, 32'h0, 4'b0000);
        drive_req(1, 32'h204, 32'h0, 4'b0000);
        run_idle(40);

        // Write payload latched at grant; later changes ignored.
        ack_wait = 3;
        expect_done(1'b1, 32'h0, 1'b0);
        drive_req(1, 32'h22, 32'h0000ABCD, 4'b0011);
        @(negedge clk);
        check_val("wr_mem_req", {31'b0, bus.mem_req}, 32'd1);
        check_val("wr_mem_addr", bus.mem_addr, 32'h22);
        check_val("wr_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'h3);
        check_val("wr_mem_wdata", bus.mem_wdata, 32'h0000ABCD);
        bus.m1_addr = 32'h99; bus.m1_wstrb = 4'b1111; bus.m1_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("wr_hold_addr", bus.mem_addr, 32'h22);
            check_val("wr_hold_wstrb", {28'b0, bus.mem_wstrb}, 32'h3);
            check_val("wr_hold_wdata", bus.mem_wdata, 32'h0000ABCD);
        end
        run_idle(20);

        // Back-to-back: three transactions, one every 3 cycles.
        ack_wait = 0;
        for (int i = 0; i < 3; i++) expect_done(1'b0, rd_fn(32'h44), 1'b0);
        drive_req(0, 32'h44, 32'h0, 4'b0000);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check_val("b2b_done", {31'b0, bus.m0_done}, {31'b0, (i % 3) == 2});
            check_val("b2b_busy", {31'b0, busy}, {31'b0, (i % 3) != 0});
            if (i == 8) bus.m0_req = 1'b0;
        end
        @(negedge clk);
        check_val("b2b_idle_busy", {31'b0, busy}, 32'd0);
        check_val("b2b_sb", 32'(exp_q.size()), 32'd0);

        // Reset during BUSY, then a late ack.
        mem_en = 1'b0;
        drive_req(0, 32'h40, 32'h0, 4'b0000);
        @(negedge clk);
        check_val("mrst_mem_req", {31'b0, bus.mem_req}, 32'd1);
        @(negedge clk);
        bus.m0_req = 1'b0;
        reset = 1'b1;
        #1;
        check_val("mrst_mem_req0", {31'b0, bus.mem_req}, 32'd0);
        check_val("mrst_mem_addr", bus.mem_addr, 32'd0);
        check_val("mrst_busy", {31'b0, busy}, 32'd0);
        check_val("mrst_rdata0", bus.m0_rdata, 32'd0);
        check_val("mrst_rdata1", bus.m1_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("late_ack_done", {30'b0, bus.m1_done, bus.m0_done}, 32'd0);
            check_val("late_ack_busy", {31'b0, busy}, 32'd0);
            check_val("late_ack_mem_req", {31'b0, bus.mem_req}, 32'd0);
        end
        mem_en = 1'b1;

        // Pointer restored by reset: m0 wins the tie.
        ack_wait = 0;
        expect_done(1'b0, rd_fn(32'h108), 1'b0);
        expect_done(1'b1, rd_fn(32'h208), 1'b0);
        drive_req(0, 32'h108, 32'h0, 4'b0000);
        drive_req(1, 32'h208, 32'h0, 4'b0000);
        run_idle(40);

`ifdef DBUS_TIMEOUT_EN
        // No ack: error completion after 4 BUSY cycles.
        mem_en = 1'b0;
        expect_done(1'b0, 32'h0, 1'b1);
        drive_req(0, 32'h30, 32'h0, 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_val("to_done", {31'b0, bus.m0_done}, {31'b0, i == 5});
        end
        bus.m0_req = 1'b0;
        run_idle(10);

        // Ack in the 4th BUSY cycle beats the expiry.
        mem_en   = 1'b1;
        ack_wait = 3;
        expect_done(1'b0, rd_fn(32'h30), 1'b0);
        drive_req(0, 32'h30, 32'h0, 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_val("to_ack_done", {31'b0, bus.m0_done}, {31'b0, i == 5});
        end
        bus.m0_req = 1'b0;
        run_idle(10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master, one-slave arbiter for the data RAM port. It shares a single data RAM between the CPU load/store path (master 0) and a loader/DMA port (master 1). Requests are granted round-robin and each transaction is held until the RAM acknowledges it. Each master receives a one-cycle done pulse with the read data.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 16, maximum BUSY cycles without mem_ack (used only with DBUS_TIMEOUT_EN); legal range ≥2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- mN_req  in  1  request from master N (N=0,1); held until mN_done
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  store data
- mN_wstrb  in  DATA_W/8  byte strobes; all zero means read
- mN_done  out  1  one-cycle completion pulse
- mN_rdata  out  DATA_W  read data, valid when mN_done=1
- mN_err  out  1  timeout flag, valid when mN_done=1
- mem_req  out  1  RAM access strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_wstrb  out  DATA_W/8  latched strobes
- mem_ack  in  1  RAM completion; one cycle or more after mem_req rises
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- busy  out  1  high in BUSY or RESP; CPU-side stall source

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any mN_req is high: pick a winner, latch its addr/wdata/wstrb into the mem_* registers, record the grant index, go to BUSY.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester wins.
  - If both request, the master not granted last wins.
  - The last-grant pointer updates only on grant. Its reset value makes master 0 win the first tie.
- BUSY:
  - mem_req=1.
  - On mem_ack: capture mem_rdata (zero on writes), clear err, go to RESP.
- RESP:
  - mN_done=1 for the granted master only, with registered mN_rdata/mN_err.
  - mem_req=0.
  - Next state is always IDLE.
- Masters must drop mN_req in the cycle after mN_done, otherwise a new transaction is started.
- Payload changes after the grant have no effect on the current transaction.
- A request arriving during BUSY/RESP waits and is arbitrated in the next IDLE.
- Reset, including mid-transaction:
  - State goes to IDLE.
  - mem_req, mem_addr, mem_wdata, mem_wstrb, all mN_done/mN_rdata/mN_err, busy go to 0.
  - Pointer goes to favour master 0.
  - An in-flight RAM access is abandoned and a late mem_ack is ignored.
- mem_ack outside BUSY is ignored.

## Timing
- Request high at edge k (IDLE) → BUSY from k+1 with mem_req=1.
- mem_ack seen at edge k+1+w (w≥0 wait cycles) → mN_done pulse in the following cycle.
- Minimum latency from request to done is 2 cycles. Back-to-back throughput is one transaction per 3 cycles.
- busy is a registered output, high from the cycle after grant through RESP.

## Configuration
- DBUS_TIMEOUT_EN defined:
  - A cycle counter (width $clog2(TIMEOUT+1)) runs in BUSY and clears on entry.
  - At TIMEOUT cycles with no mem_ack: go to RESP with mN_err=1 and mN_rdata=0.
  - mem_ack in the same cycle as expiry wins, giving a normal completion.
- Not defined: no counter, BUSY waits indefinitely, mN_err is tied to 0.

## Structure
- dbus_pkg holds:
  - state enum typedef (IDLE/BUSY/RESP)
  - master-index typedef (1 bit)
  - WSTRB_READ constant (all zeros)
  - parameter defaults
- Sub-module rr_arbiter2:
  - inputs: req[1:0] and a grant_en strobe
  - outputs: one-hot gnt
  - owns the last-grant pointer register (asynchronous reset)

## Test plan
- Single read: m0 read at 0x10, mem_ack after 2 wait cycles with mem_rdata=0xDEADBEEF → m0_done 1 cycle later, m0_rdata=0xDEADBEEF, m1_done stays 0.
- Tie after reset: m0 and m1 request in the same cycle → m0 served first, then m1. Repeating the tie serves m1 first.
- Write payload latch: m1 writes wstrb=4'b0011, wdata=0x0000ABCD at 0x22, then changes its addr during BUSY → mem_addr stays 0x22 and mem_wstrb stays 0011 until mem_ack.
- Back-to-back: m0 holds its request for 3 transactions with mem_ack immediate → done pulses every 3 cycles and busy drops for exactly one IDLE cycle between them.
- Reset mid-BUSY: assert reset while mem_req=1, then deliver a late mem_ack → all outputs go to 0, no done pulse, FSM in IDLE.
- Timeout (DBUS_TIMEOUT_EN, TIMEOUT=4): no mem_ack → done with err=1 and rdata=0 after 4 BUSY cycles. Repeat with mem_ack on the 4th cycle → err=0.
